// File: rtl/cpu_mem_bridge.sv
// Bridges the CPU 20-bit byte bus to a 16-bit word memory with a req/ready handshake.
// Each new bus tuple becomes one memory access; a one-word read buffer serves same-word reads.
module cpu_mem_bridge #(
  parameter int unsigned MAXWAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  o_data,
  input  logic        we,
  output logic [7:0]  i_data,
  output logic [18:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e r_state, w_state_nxt;

  // Registered image of the CPU bus; the trigger compares against this.
  logic [19:0] r_bus_addr;
  logic [7:0]  r_bus_data;
  logic        r_bus_we;

  logic [19:0] r_srv_addr, r_lat_addr;
  logic [7:0]  r_srv_data, r_lat_data;
  logic        r_srv_we, r_lat_we, r_srv_valid;

  logic [15:0] r_buf;
  logic [18:0] r_tag;
  logic        r_buf_valid;

  logic [7:0]  r_i_data;
  logic [18:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [1:0]  r_mem_be;
  logic        r_mem_we;

  logic w_trig, w_bus_hit, w_hit, w_start_rd, w_start_wr, w_rd_done, w_wr_done, w_lat_tag_hit;

  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

  always_ff @(posedge clock) begin
    r_bus_addr <= address;
    r_bus_data <= o_data;
    r_bus_we   <= we;
  end

  always_comb begin
    w_trig        = !r_srv_valid ||
                    ({r_bus_addr, r_bus_we, r_bus_data} != {r_srv_addr, r_srv_we, r_srv_data});
    w_bus_hit     = r_buf_valid && (r_tag == r_bus_addr[19:1]);
    w_lat_tag_hit = r_buf_valid && (r_tag == r_lat_addr[19:1]);
    w_state_nxt   = r_state;
    w_hit         = 1'b0;
    w_start_rd    = 1'b0;
    w_start_wr    = 1'b0;
    w_rd_done     = 1'b0;
    w_wr_done     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_trig) begin
          if (r_bus_we) begin
            w_start_wr  = 1'b1;
            w_state_nxt = StWr;
          end else if (w_bus_hit) begin
            w_hit = 1'b1;
          end else begin
            w_start_rd  = 1'b1;
            w_state_nxt = StRd;
          end
        end
      end
      StRd: begin
        if (mem_ready) begin
          w_rd_done   = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StWr: begin
        if (mem_ready) begin
          w_wr_done   = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_srv_addr  <= '0;
      r_srv_data  <= '0;
      r_srv_we    <= 1'b0;
      r_srv_valid <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_data  <= '0;
      r_lat_we    <= 1'b0;
      r_buf       <= '0;
      r_tag       <= '0;
      r_buf_valid <= 1'b0;
      r_i_data    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hit) begin
        r_i_data    <= sel_byte(r_buf, r_bus_addr[0]);
        r_srv_addr  <= r_bus_addr;
        r_srv_data  <= r_bus_data;
        r_srv_we    <= r_bus_we;
        r_srv_valid <= 1'b1;
      end
      // Memory-side fields are frozen here for the whole req window.
      if (w_start_rd || w_start_wr) begin
        r_lat_addr  <= r_bus_addr;
        r_lat_data  <= r_bus_data;
        r_lat_we    <= r_bus_we;
        r_mem_addr  <= r_bus_addr[19:1];
        r_mem_wdata <= {r_bus_data, r_bus_data};
        r_mem_we    <= w_start_wr;
        r_mem_be    <= w_start_rd ? 2'b11 : (r_bus_addr[0] ? 2'b10 : 2'b01);
      end
      if (w_rd_done) begin
        r_buf       <= mem_rdata;
        r_tag       <= r_lat_addr[19:1];
        r_buf_valid <= 1'b1;
        r_i_data    <= sel_byte(mem_rdata, r_lat_addr[0]);
      end
      if (w_wr_done) begin
        r_i_data <= r_lat_data;
        if (w_lat_tag_hit) begin
          if (r_lat_addr[0]) r_buf[15:8] <= r_lat_data;
          else               r_buf[7:0]  <= r_lat_data;
        end
      end
      if (w_rd_done || w_wr_done) begin
        r_srv_addr  <= r_lat_addr;
        r_srv_data  <= r_lat_data;
        r_srv_we    <= r_lat_we;
        r_srv_valid <= 1'b1;
      end
    end
  end

  assign i_data      = r_i_data;
  assign mem_address = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;
  assign mem_we      = r_mem_we;
  assign mem_req     = (r_state != StIdle);

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge with a small req/ready memory responder.
module tb_cpu_mem_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] address;
  logic [7:0]  o_data;
  logic        we;
  logic [7:0]  i_data;
  logic [18:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_we;
  logic        mem_req;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Responder state and transaction log
  int          req_count = 0;
  int          unstable  = 0;
  int          cnt       = 0;
  int          wait_n    = 0;
  logic        hold_low  = 1'b0;
  logic        prev_req  = 1'b0;
  logic [15:0] mem_word  = '0;
  logic [18:0] cap_addr  = '0;
  logic [15:0] cap_wdata = '0;
  logic [1:0]  cap_be    = '0;
  logic        cap_we    = 1'b0;
  int          base;

  cpu_mem_bridge #(.MAXWAIT(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .o_data      (o_data),
    .we          (we),
    .i_data      (i_data),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_we      (mem_we),
    .mem_req     (mem_req),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_req && !prev_req) begin
      req_count = req_count + 1;
      cap_addr  = mem_address;
      cap_wdata = mem_wdata;
      cap_be    = mem_be;
      cap_we    = mem_we;
      cnt       = 0;
    end else if (mem_req) begin
      if (mem_address != cap_addr || mem_wdata != cap_wdata || mem_be != cap_be ||
          mem_we != cap_we) unstable = unstable + 1;
      cnt = cnt + 1;
    end
    mem_ready = mem_req && !hold_low && (cnt >= wait_n);
    mem_rdata = mem_word;
    prev_req  = mem_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    address  = 20'h00000;
    o_data   = 8'h00;
    we       = 1'b0;
    mem_word = 16'h1234;
    step(3);
    check("rst_i_data", {24'h0, i_data}, 32'h00);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_be", {30'h0, mem_be}, 32'h0);
    check("rst_addr", {13'h0, mem_address}, 32'h0);
    check("rst_wdata", {16'h0, mem_wdata}, 32'h0);

    // First cycle out of reset reads address 0
    reset = 1'b0;
    step(2);
    check("boot_rd_data", {24'h0, i_data}, 32'h34);
    check("boot_rd_cnt", req_count, 1);

    // Read miss, zero wait
    step(1);
    address  = 20'h00010;
    mem_word = 16'hBEEF;
    step(2);
    check("miss_req_hi", {31'h0, mem_req}, 32'h1);
    step(1);
    check("miss_data", {24'h0, i_data}, 32'hEF);
    check("miss_req_lo", {31'h0, mem_req}, 32'h0);
    check("miss_addr", {13'h0, cap_addr}, 32'h00008);
    check("miss_be", {30'h0, cap_be}, 32'h3);
    check("miss_cnt", req_count, 2);

    // Buffer hit on the other byte
    address = 20'h00011;
    step(2);
    check("hit_data", {24'h0, i_data}, 32'hBE);
    check("hit_no_req", req_count, 2);

    // Write held four cycles commits once
    we      = 1'b1;
    o_data  = 8'h5A;
    step(4);
    check("wr_cnt", req_count, 3);
    check("wr_we", {31'h0, cap_we}, 32'h1);
    check("wr_be", {30'h0, cap_be}, 32'h2);
    check("wr_wdata", {16'h0, cap_wdata}, 32'h5A5A);
    check("wr_addr", {13'h0, cap_addr}, 32'h00008);
    check("wr_i_data", {24'h0, i_data}, 32'h5A);

    // Unpatched low byte, then patched high byte, both from the buffer
    we      = 1'b0;
    address = 20'h00010;
    step(3);
    check("hit_lo", {24'h0, i_data}, 32'hEF);
    address = 20'h00011;
    step(3);
    check("hit_patched", {24'h0, i_data}, 32'h5A);
    check("hit_patched_cnt", req_count, 3);

    // Delayed read with a bus change mid-access
    wait_n   = 1;
    mem_word = 16'hCAFE;
    address  = 20'h00200;
    step(2);
    check("dly_req_hi", {31'h0, mem_req}, 32'h1);
    check("dly_addr", {13'h0, mem_address}, 32'h00100);
    address = 20'h00100;
    step(1);
    check("dly_wait_req", {31'h0, mem_req}, 32'h1);
    check("dly_stable", {13'h0, mem_address}, 32'h00100);
    step(1);
    check("dly_data", {24'h0, i_data}, 32'hFE);
    check("dly_idle_gap", {31'h0, mem_req}, 32'h0);
    mem_word = 16'h1177;
    step(1);
    check("dly2_req_hi", {31'h0, mem_req}, 32'h1);
    check("dly2_addr", {13'h0, mem_address}, 32'h00080);
    check("dly2_cnt", req_count, 5);
    step(2);
    check("dly2_data", {24'h0, i_data}, 32'h77);
    check("dly2_req_lo", {31'h0, mem_req}, 32'h0);
    check("no_unstable", unstable, 0);

    // Reset while a write waits on ready
    wait_n   = 0;
    hold_low = 1'b1;
    we       = 1'b1;
    o_data   = 8'h33;
    address  = 20'h00100;
    step(2);
    check("rwr_req", {31'h0, mem_req}, 32'h1);
    check("rwr_we", {31'h0, mem_we}, 32'h1);
    base    = req_count;
    reset   = 1'b1;
    we      = 1'b0;
    step(1);
    check("rwr_req_drop", {31'h0, mem_req}, 32'h0);
    check("rwr_i_data", {24'h0, i_data}, 32'h00);
    reset    = 1'b0;
    hold_low = 1'b0;
    mem_word = 16'h4455;
    step(1);
    check("post_rst_req", {31'h0, mem_req}, 32'h1);
    check("post_rst_addr", {13'h0, mem_address}, 32'h00080);
    step(1);
    check("post_rst_data", {24'h0, i_data}, 32'h55);
    check("post_rst_cnt", req_count, base + 1);

    // Top of address space, high byte
    mem_word = 16'h9A3C;
    address  = 20'hFFFFF;
    step(2);
    check("top_addr", {13'h0, mem_address}, 32'h7FFFF);
    check("top_be", {30'h0, mem_be}, 32'h3);
    step(1);
    check("top_data", {24'h0, i_data}, 32'h9A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
